statelogic: RTL and testbench
=============================

# statelogic

Main control state machine for the multicycle 8-bit MIPS datapath. It holds the 4-bit control state and computes the next state from the current state and the instruction opcode. Its `state` output drives the combinational output-decode block directly, and that block produces every datapath control strobe. One instruction is walked through fetch (four byte fetches), decode, execute, memory and writeback, then control returns to fetch.

## Interface
Parameters: none (state encoding fixed below).
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high; forces FETCH1 on next rising edge
- op  input  6  opcode from instruction register bits [31:26]; stable from DECODE until return to FETCH1
- stall  input  1  when high, state register holds its value; reset overrides
- state  output  4  registered current control state, consumed by output decode
- illegal_op  output  1  registered one-cycle pulse: undecodable opcode seen in DECODE

## Operation
- State encoding (fixed; output decode depends on it):
  - FETCH1=0, FETCH2=1, FETCH3=2, FETCH4=3, DECODE=4
  - MEMADR=5, LBRD=6, LBWR=7, SBWR=8
  - RTYPEEX=9, RTYPEWR=10, BEQEX=11, JEX=12
  - ADDIEX=13, ADDIWR=14 (only with macro)
  - 15 is unused
- Opcodes: LB=6'b100000, SB=6'b101000, RTYPE=6'b000000, BEQ=6'b000100, J=6'b000010, ADDI=6'b001000.
- Fetch transitions: FETCH1→FETCH2→FETCH3→FETCH4→DECODE, unconditional.
- DECODE dispatch:
  - LB or SB → MEMADR
  - RTYPE → RTYPEEX
  - BEQ → BEQEX
  - J → JEX
  - ADDI → ADDIEX (macro only)
  - any other opcode → FETCH1, with illegal_op=1 in the following cycle
- MEMADR: LB → LBRD; SB → SBWR; any other opcode → FETCH1 (no flag).
- Completion paths:
  - LBRD→LBWR→FETCH1
  - SBWR→FETCH1
  - RTYPEEX→RTYPEWR→FETCH1
  - BEQEX→FETCH1
  - JEX→FETCH1
  - ADDIEX→ADDIWR→FETCH1
- Unused codes (15, and 13/14 when the macro is off) → FETCH1 on the next edge, no flag. No lock-up state.
- Instruction lengths in cycles, FETCH1 through last state inclusive:
  - LB 8
  - SB 7
  - RTYPE 7
  - BEQ 6
  - J 6
  - ADDI 7
  - illegal 5

## Timing
- Reset values: state=0 (FETCH1), illegal_op=0. Reset mid-instruction aborts it; FETCH1 appears the cycle after the reset edge.
- Next state is a combinational function of (state, op). It is registered on the rising edge, so there is one cycle of latency from decision to `state` output.
- stall=1: state and op-dependent decisions freeze, and illegal_op is forced 0. If stall and reset are asserted together, reset wins.
- illegal_op:
  - asserts on the same edge that moves DECODE→FETCH1
  - is high for exactly one cycle
  - is never asserted while state≠FETCH1
- op is sampled only in DECODE and MEMADR. Changes in other states have no effect.
- Back-to-back instructions have no idle cycle: the last state of an instruction is followed immediately by FETCH1.

## Configuration
- Macro `STATELOGIC_ADDI_EN`:
  - Defined: ADDI is decoded; DECODE→ADDIEX→ADDIWR→FETCH1.
  - Undefined: ADDI is treated as illegal (DECODE→FETCH1 plus illegal_op pulse). Codes 13/14 are unreachable and recover to FETCH1.
- The output decode must be built with the same setting.

## Test plan
- Reset then LB:
  - stimulus: reset=1 for 2 cycles, op=6'b100000
  - expected state sequence: 0,1,2,3,4,5,6,7,0
  - illegal_op stays 0
- SB then RTYPE back-to-back:
  - SB sequence: 0,1,2,3,4,5,8,0
  - op switched to 0 during FETCH1, then: 1,2,3,4,9,10,0
- BEQ and J:
  - BEQ: op=6'b000100 gives 4→11→0
  - J: op=6'b000010 gives 4→12→0
- Illegal opcode:
  - stimulus: op=6'b111111
  - expected: 4→0, with illegal_op=1 for exactly one cycle while state=0
  - with the macro undefined, op=6'b001000 behaves the same way
  - with the macro defined, op=6'b001000 gives 4→13→14→0
- Stall and reset priority:
  - stall=1 for 3 cycles while in state 6: state holds 6
  - stall released: state goes 7 then 0
  - reset asserted with stall=1 in state 9: state=0 next cycle
- Recovery: force state to 15 via reset-free hierarchical deposit → state=0 next edge, illegal_op=0.

Source files
------------

// File: rtl/statelogic.sv
// Main control FSM for the multicycle 8-bit MIPS datapath: four-byte fetch, decode, execute,
// memory and writeback. Optional ADDI support is enabled by defining STATELOGIC_ADDI_EN.
module statelogic (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       stall,
  output logic [3:0] state,
  output logic       illegal_op
);

  // Encoding is fixed: the output-decode block keys directly off these codes.
  typedef enum logic [3:0] {
    Fetch1  = 4'd0,
    Fetch2  = 4'd1,
    Fetch3  = 4'd2,
    Fetch4  = 4'd3,
    Decode  = 4'd4,
    MemAdr  = 4'd5,
    LbRd    = 4'd6,
    LbWr    = 4'd7,
    SbWr    = 4'd8,
    RtypeEx = 4'd9,
    RtypeWr = 4'd10,
    BeqEx   = 4'd11,
    JEx     = 4'd12,
    AddiEx  = 4'd13,
    AddiWr  = 4'd14
  } state_e;

  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpSb    = 6'b101000;
  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
`ifdef STATELOGIC_ADDI_EN
  localparam logic [5:0] OpAddi  = 6'b001000;
`endif

  // Kept as raw bits so any code, including the unused 15, decodes through the default arm.
  logic [3:0] state_q;
  state_e     state_d;
  logic       illegal_q;
  logic       illegal_d;

  always_comb begin
    state_d   = Fetch1;
    illegal_d = 1'b0;
    case (state_e'(state_q))
      Fetch1:  state_d = Fetch2;
      Fetch2:  state_d = Fetch3;
      Fetch3:  state_d = Fetch4;
      Fetch4:  state_d = Decode;
      Decode: begin
        case (op)
          OpLb, OpSb: state_d = MemAdr;
          OpRtype:    state_d = RtypeEx;
          OpBeq:      state_d = BeqEx;
          OpJ:        state_d = JEx;
`ifdef STATELOGIC_ADDI_EN
          OpAddi:     state_d = AddiEx;
`endif
          default: begin
            state_d   = Fetch1;
            illegal_d = 1'b1;
          end
        endcase
      end
      MemAdr: begin
        // op changing after decode is not flagged; the instruction is simply dropped.
        case (op)
          OpLb:    state_d = LbRd;
          OpSb:    state_d = SbWr;
          default: state_d = Fetch1;
        endcase
      end
      LbRd:    state_d = LbWr;
      LbWr:    state_d = Fetch1;
      SbWr:    state_d = Fetch1;
      RtypeEx: state_d = RtypeWr;
      RtypeWr: state_d = Fetch1;
      BeqEx:   state_d = Fetch1;
      JEx:     state_d = Fetch1;
`ifdef STATELOGIC_ADDI_EN
      AddiEx:  state_d = AddiWr;
      AddiWr:  state_d = Fetch1;
`endif
      default: state_d = Fetch1;
    endcase

    if (stall) begin
      state_d   = state_e'(state_q);
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= 4'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  assign state      = state_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_statelogic.sv
// Self-checking bench for statelogic: a vector table drives one row per cycle and pushes the
// expected post-edge outputs onto a scoreboard that a monitor pops one cycle later.
module tb_statelogic;

  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] SB  = 6'b101000;
  localparam logic [5:0] RT  = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] ADI = 6'b001000;
  localparam logic [5:0] BAD = 6'b111111;

  typedef struct packed {
    logic       rst;
    logic       stl;
    logic [5:0] op;
    logic [3:0] st;
    logic       ill;
  } vec_t;

  typedef struct packed {
    logic [3:0]  st;
    logic        ill;
    int unsigned idx;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       stall;
  logic [3:0] state;
  logic       illegal_op;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks;
  int   fails;

  statelogic dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .stall      (stall),
    .state      (state),
    .illegal_op (illegal_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void add(input logic r, input logic s, input logic [5:0] o,
                              input logic [3:0] st, input logic ill);
    vec_t v;
    v.rst = r;
    v.stl = s;
    v.op  = o;
    v.st  = st;
    v.ill = ill;
    vecs.push_back(v);
  endfunction

  // Fetch and decode cycles (states after edge: 1,2,3,4) with the given op held throughout.
  function automatic void fetch(input logic [5:0] o);
    add(1'b0, 1'b0, o, 4'd1, 1'b0);
    add(1'b0, 1'b0, o, 4'd2, 1'b0);
    add(1'b0, 1'b0, o, 4'd3, 1'b0);
    add(1'b0, 1'b0, o, 4'd4, 1'b0);
  endfunction

  // Scoreboard consumer: each expectation covers the edge just after it was pushed.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (state !== e.st || illegal_op !== e.ill) begin
        fails++;
        $display("FAIL vec%0d: got state=%0d illegal_op=%0b, required state=%0d illegal_op=%0b",
                 e.idx, state, illegal_op, e.st, e.ill);
      end
    end
  end

  initial begin
    exp_t e;
    int   waited;
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    stall  = 1'b0;
    op     = LB;

    // Reset then LB: 0,1,2,3,4,5,6,7,0
    add(1'b1, 1'b0, LB, 4'd0, 1'b0);
    add(1'b1, 1'b0, LB, 4'd0, 1'b0);
    fetch(LB);
    add(1'b0, 1'b0, LB, 4'd5, 1'b0);
    add(1'b0, 1'b0, LB, 4'd6, 1'b0);
    add(1'b0, 1'b0, LB, 4'd7, 1'b0);
    add(1'b0, 1'b0, LB, 4'd0, 1'b0);
    // SB then RTYPE back-to-back
    fetch(SB);
    add(1'b0, 1'b0, SB, 4'd5, 1'b0);
    add(1'b0, 1'b0, SB, 4'd8, 1'b0);
    add(1'b0, 1'b0, SB, 4'd0, 1'b0);
    fetch(RT);
    add(1'b0, 1'b0, RT, 4'd9, 1'b0);
    add(1'b0, 1'b0, RT, 4'd10, 1'b0);
    add(1'b0, 1'b0, RT, 4'd0, 1'b0);
    // BEQ and J
    fetch(BEQ);
    add(1'b0, 1'b0, BEQ, 4'd11, 1'b0);
    add(1'b0, 1'b0, BEQ, 4'd0, 1'b0);
    fetch(J);
    add(1'b0, 1'b0, J, 4'd12, 1'b0);
    add(1'b0, 1'b0, J, 4'd0, 1'b0);
    // Illegal opcode: one-cycle pulse while in FETCH1
    fetch(BAD);
    add(1'b0, 1'b0, BAD, 4'd0, 1'b1);
    add(1'b0, 1'b0, BAD, 4'd1, 1'b0);
    add(1'b0, 1'b0, J, 4'd2, 1'b0);
    add(1'b0, 1'b0, J, 4'd3, 1'b0);
    add(1'b0, 1'b0, J, 4'd4, 1'b0);
    add(1'b0, 1'b0, J, 4'd12, 1'b0);
    add(1'b0, 1'b0, J, 4'd0, 1'b0);
    // ADDI depends on build setting
    fetch(ADI);
`ifdef STATELOGIC_ADDI_EN
    add(1'b0, 1'b0, ADI, 4'd13, 1'b0);
    add(1'b0, 1'b0, ADI, 4'd14, 1'b0);
    add(1'b0, 1'b0, ADI, 4'd0, 1'b0);
`else
    add(1'b0, 1'b0, ADI, 4'd0, 1'b1);
`endif
    // op ignored outside DECODE/MEMADR; MEMADR with changed op drops to FETCH1 silently
    add(1'b0, 1'b0, BAD, 4'd1, 1'b0);
    add(1'b0, 1'b0, BAD, 4'd2, 1'b0);
    add(1'b0, 1'b0, BAD, 4'd3, 1'b0);
    add(1'b0, 1'b0, BAD, 4'd4, 1'b0);
    add(1'b0, 1'b0, LB, 4'd5, 1'b0);
    add(1'b0, 1'b0, J, 4'd0, 1'b0);
    // Stall in LBRD holds, then completes
    fetch(LB);
    add(1'b0, 1'b0, LB, 4'd5, 1'b0);
    add(1'b0, 1'b0, LB, 4'd6, 1'b0);
    add(1'b0, 1'b1, BAD, 4'd6, 1'b0);
    add(1'b0, 1'b1, BAD, 4'd6, 1'b0);
    add(1'b0, 1'b1, BAD, 4'd6, 1'b0);
    add(1'b0, 1'b0, LB, 4'd7, 1'b0);
    add(1'b0, 1'b0, LB, 4'd0, 1'b0);
    // Stall in DECODE with illegal op suppresses the flag until released
    fetch(BAD);
    add(1'b0, 1'b1, BAD, 4'd4, 1'b0);
    add(1'b0, 1'b1, BAD, 4'd4, 1'b0);
    add(1'b0, 1'b0, BAD, 4'd0, 1'b1);
    // Reset beats stall in RTYPEEX
    fetch(RT);
    add(1'b0, 1'b0, RT, 4'd9, 1'b0);
    add(1'b1, 1'b1, RT, 4'd0, 1'b0);
    add(1'b0, 1'b0, RT, 4'd1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      reset = vecs[i].rst;
      stall = vecs[i].stl;
      op    = vecs[i].op;
      e.st  = vecs[i].st;
      e.ill = vecs[i].ill;
      e.idx = i;
      exp_q.push_back(e);
    end

    // Recovery from the unused code 15
    @(negedge clk);
    reset = 1'b0;
    stall = 1'b0;
    op    = BAD;
    force dut.state_q = 4'd15;
    #1;
    release dut.state_q;
    e.st  = 4'd0;
    e.ill = 1'b0;
    e.idx = 1000;
    exp_q.push_back(e);

    waited = 0;
    while (exp_q.size() > 0 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
